// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant hold limit and timeout pulse.
// The owner-done input is named rel because release is a reserved word in SystemVerilog.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       rel,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [3:0]       gnt_d;
    logic             timeout_d;
    logic [CNT_W-1:0] hold_cnt, hold_d;
    logic [1:0]       last, last_d;
    logic [1:0]       owner, owner_d;
    logic             hold_hit;
    logic             revoke;

    // First requester found when searching upward from last+1 with wrap.
    function automatic logic [1:0] pick_next(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] idx;
        logic       found;
        pick_next = '0;
        found     = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = l + 2'(k);
            if (!found && r[idx]) begin
                pick_next = idx;
                found     = 1'b1;
            end
        end
    endfunction

    assign hold_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign revoke   = rel || !req[owner] || hold_hit;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        gnt_d     = gnt;
        timeout_d = 1'b0;
        hold_d    = hold_cnt;
        last_d    = last;
        owner_d   = owner;
        case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (req != 4'b0000) begin
                    owner_d = pick_next(req, last);
                    gnt_d   = 4'b0001 << owner_d;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (revoke) begin
                    gnt_d     = 4'b0000;
                    state_d   = IDLE;
                    last_d    = owner;
                    hold_d    = '0;
                    // Pulse only when the hold limit alone ended the grant.
                    timeout_d = hold_hit && !rel && req[owner];
                end else if (hold_cnt != '1) begin
                    hold_d = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update together on the edge.
        if (rst) begin
            state_q   <= IDLE;
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
            last      <= 2'd3;
            owner     <= 2'd0;
        end else begin
            state_q   <= state_d;
            gnt       <= gnt_d;
            gnt_valid <= |gnt_d;
            timeout   <= timeout_d;
            hold_cnt  <= hold_d;
            last      <= last_d;
            owner     <= owner_d;
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed vector table, timeout sequences and a randomized model-checked run for rr_arbiter4.
module tb_rr_arbiter4;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rel;
        logic [3:0] gnt;
        logic       valid;
        logic       to;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       rel;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic l,
                       input logic [3:0] g, input logic t);
        vecs.push_back('{rst: r, req: q, rel: l, gnt: g, valid: |g, to: t});
    endtask

    function automatic logic [3:0] expect_pick(input logic [3:0] r, input int l);
        for (int k = 1; k <= 4; k++) begin
            if (r[(l + k) % 4]) return 4'b0001 << ((l + k) % 4);
        end
        return 4'b0000;
    endfunction

    function automatic int idx_of(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return 0;
    endfunction

    initial begin
        int         last_b;
        int         held;
        int         wait_n[4];
        logic [3:0] prev_gnt, exp_gnt, req_a;
        logic       rel_a, rev, exp_to;
        int         own;

        rst = 1'b1;
        req = 4'b0000;
        rel = 1'b0;

        // Single requester, grant dropped when its request falls.
        add(1, 4'b0000, 0, 4'b0000, 0);
        add(0, 4'b0001, 0, 4'b0001, 0);
        add(0, 4'b0001, 0, 4'b0001, 0);
        add(0, 4'b0001, 0, 4'b0001, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        // Full rotation with release one cycle after each grant.
        add(1, 4'b0000, 0, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0001, 0);
        add(0, 4'b1111, 1, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0010, 0);
        add(0, 4'b1111, 1, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0100, 0);
        add(0, 4'b1111, 1, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b1000, 0);
        add(0, 4'b1111, 1, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0001, 0);
        add(0, 4'b1111, 1, 4'b0000, 0);
        // Simultaneous requests after serving requester 1.
        add(0, 4'b0010, 0, 4'b0010, 0);
        add(0, 4'b0010, 1, 4'b0000, 0);
        add(0, 4'b1011, 0, 4'b1000, 0);
        add(0, 4'b1011, 1, 4'b0000, 0);
        add(0, 4'b1011, 0, 4'b0001, 0);
        add(0, 4'b0011, 0, 4'b0001, 0);
        // Release in IDLE ignored, non-owner changes ignored, reset mid-grant.
        add(0, 4'b0000, 1, 4'b0000, 0);
        add(0, 4'b0010, 1, 4'b0010, 0);
        add(0, 4'b0110, 0, 4'b0010, 0);
        add(0, 4'b1010, 0, 4'b0010, 0);
        add(0, 4'b0011, 0, 4'b0010, 0);
        add(1, 4'b1111, 0, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0001, 0);
        add(0, 4'b1111, 1, 4'b0000, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            req = vecs[i].req;
            rel = vecs[i].rel;
            step();
            check($sformatf("row%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            check($sformatf("row%0d gnt_valid", i), 32'(gnt_valid), 32'(vecs[i].valid));
            check($sformatf("row%0d timeout", i), 32'(timeout), 32'(vecs[i].to));
        end

        // Hold limit: exactly 8 cycles of grant, one timeout pulse, then regrant.
        rst = 1'b0;
        req = 4'b0100;
        rel = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            check($sformatf("hold%0d gnt", c), 32'(gnt), 32'(4'b0100));
            check($sformatf("hold%0d timeout", c), 32'(timeout), 32'd0);
        end
        step();
        check("expire gnt", 32'(gnt), 32'd0);
        check("expire gnt_valid", 32'(gnt_valid), 32'd0);
        check("expire timeout", 32'(timeout), 32'd1);
        step();
        check("regrant gnt", 32'(gnt), 32'(4'b0100));
        check("regrant timeout", 32'(timeout), 32'd0);
        // Release coinciding with expiry suppresses the timeout pulse.
        for (int c = 0; c < 7; c++) step();
        check("pre-expire gnt", 32'(gnt), 32'(4'b0100));
        rel = 1'b1;
        step();
        check("rel-expire gnt", 32'(gnt), 32'd0);
        check("rel-expire timeout", 32'(timeout), 32'd0);
        rel = 1'b0;
        req = 4'b0000;
        step();

        // Randomized run against a behavioural model of the arbitration rules.
        rst = 1'b1;
        step();
        rst      = 1'b0;
        last_b   = 3;
        held     = 0;
        prev_gnt = 4'b0000;
        foreach (wait_n[i]) wait_n[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            rel   = ($urandom_range(0, 9) == 0);
            req_a = req;
            rel_a = rel;
            step();
            if (prev_gnt == 4'b0000) begin
                exp_gnt = expect_pick(req_a, last_b);
                exp_to  = 1'b0;
            end else begin
                own     = idx_of(prev_gnt);
                rev     = rel_a || !req_a[own] || (held == 8);
                exp_gnt = rev ? 4'b0000 : prev_gnt;
                exp_to  = rev && (held == 8) && !rel_a && req_a[own];
                if (rev) last_b = own;
            end
            check($sformatf("rand%0d gnt", cyc), 32'(gnt), 32'(exp_gnt));
            check($sformatf("rand%0d gnt_valid", cyc), 32'(gnt_valid), 32'(|exp_gnt));
            check($sformatf("rand%0d timeout", cyc), 32'(timeout), 32'(exp_to));
            check($sformatf("rand%0d onehot", cyc), 32'($onehot0(gnt)), 32'd1);
            if (prev_gnt == 4'b0000 && gnt != 4'b0000) begin
                check($sformatf("rand%0d gnt_to_idle_req", cyc), 32'(gnt & ~req_a), 32'd0);
                for (int i = 0; i < 4; i++) begin
                    if (gnt[i]) wait_n[i] = 0;
                    else if (req_a[i]) begin
                        wait_n[i]++;
                        check($sformatf("rand%0d fair%0d", cyc, i), 32'(wait_n[i] <= 3), 32'd1);
                    end
                end
            end
            for (int i = 0; i < 4; i++) if (!req_a[i]) wait_n[i] = 0;
            if (exp_gnt != 4'b0000 && exp_gnt == prev_gnt) held++;
            else if (exp_gnt != 4'b0000) held = 1;
            else held = 0;
            prev_gnt = exp_gnt;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter with grant hold and timeout.
- Sits directly upstream of the 4-to-2 encoder stage.
- Its registered one-hot grant vector drives the encoder inputs directly: gnt[0]..gnt[3] map to din0..din3.
- Guarantees the encoder only ever sees a single-hot or all-zero input, so the encoder never hits its undefined cases.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one grant may be held. 0 disables the timeout.
- CNT_W, 4: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req  input  4  request lines; req[i] held high while requester i wants the resource
- release  input  1  owner signals done; sampled only in GRANT
- gnt  output  4  registered one-hot grant (or 4'b0000); feeds encoder din0..din3
- gnt_valid  output  1  registered; equals OR of gnt
- timeout  output  1  registered one-cycle pulse when a grant is revoked by MAX_HOLD expiry

Behaviour:
Reset:
- rst is sampled on the rising clk edge; it overrides all other inputs.
- Reset values: gnt=0, gnt_valid=0, timeout=0, state=IDLE, hold_cnt=0, last=3.
- last=3 gives req[0] highest priority on the first arbitration.

State machine (two states, IDLE and GRANT):
- IDLE, req==0: stay in IDLE; outputs stay 0.
- IDLE, req!=0: at the next edge, select the first set bit of req, searching (last+1) mod 4 upward with wrap.
  - gnt is set to that one-hot bit; gnt_valid=1.
  - State goes to GRANT; hold_cnt=0; owner=selected index.
  - Latency from req to gnt is exactly 1 cycle.
- GRANT: gnt and owner are frozen. hold_cnt increments each cycle and saturates at 2^CNT_W-1.
- GRANT revocation conditions (evaluated every cycle):
  - (a) release=1
  - (b) req[owner]=0
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1
- If any condition holds, at the next edge: gnt=0, gnt_valid=0, state=IDLE, last=owner, hold_cnt=0.
- timeout=1 for that one cycle only when (c) holds and neither (a) nor (b) holds. Otherwise timeout=0.
- With MAX_HOLD=N and no release, the grant lasts exactly N cycles.

Boundary and priority rules:
- Mandatory idle gap: every revocation is followed by at least one cycle with gnt=0, even if other requests are pending. The encoder therefore sees a zero cycle between owners.
- Fairness: after owner i is revoked, any other pending requester is granted before i regains the resource.
- Simultaneous requests in IDLE: strict rotation from last+1. For example, last=1 and req=4'b1011 grants bit 3.
- release while in IDLE: ignored.
- Changes to non-owner req bits during GRANT: ignored.
- rst asserted during GRANT: the next edge returns all reset values. No timeout pulse is generated. last is forced to 3.

Invariants:
- gnt is never multi-hot.
- gnt is never set for an index whose req was low at the selection edge.

Test Plan:
1. Reset then req=4'b0001 for 3 cycles, then 0 -> gnt=0001 from cycle 1; revoked (req drop) so gnt=0000 the cycle after req falls; timeout=0.
2. req=4'b1111 held constant, release pulsed 1 cycle after each grant -> grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
3. MAX_HOLD=8, req=4'b0100 held, no release -> gnt=0100 for exactly 8 cycles, then gnt=0000 with timeout=1 for one cycle; regranted 0100 the following cycle.
4. Simultaneous: last=1 (after serving req1), req=4'b1011 -> next grant 1000; then release -> next grant 0001.
5. rst asserted mid-grant (gnt=0010, hold_cnt=3) -> next cycle gnt=0, gnt_valid=0, timeout=0; with req=4'b1111 the next grant is 0001.
6. Random req/release for 10k cycles with a scoreboard -> gnt always one-hot or zero, gnt_valid==|gnt, no grant to a non-requesting index, every pending requester served within 4 grants.
